// File: rtl/mips_pkg.sv
// Shared definitions for the pipe_MIPS20 execution core: opcodes, instruction
// field positions, operation classes and the immediate sign-extension helper.
package mips_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h0A;
  localparam logic [5:0] OP_SUBI = 6'h0B;
  localparam logic [5:0] OP_SLTI = 6'h0C;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {RR_ALU, RM_ALU, HALT, ILLEGAL} op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_HLT:                                        return HALT;
      default:                                       return ILLEGAL;
    endcase
  endfunction

  // Widest legal datapath is 64 bits; callers truncate to DATA_W.
  function automatic logic [63:0] sext(input logic [15:0] imm);
    return {{48{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_exec_pipe_if.sv
// Instruction stream and writeback bus of the execution core.
interface mips_exec_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (output instr_valid, instr, input instr_ready, wb_valid, wb_addr, wb_data);
  modport slave  (input instr_valid, instr, output instr_ready, wb_valid, wb_addr, wb_data);
endinterface

// File: rtl/mips_alu.sv
// Combinational integer ALU of the execute stage.
module mips_alu import mips_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [5:0]               op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);

  // Opcode-selected operation; add/sub/mul wrap, set-less-than is signed
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB, OP_SUBI: result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_SLT, OP_SLTI: result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MUL:          result = a * b;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/mips_exec_pipe.sv
// Three-stage (decode/execute/writeback) integer core with internal register
// file, execute-to-decode bypass or one-cycle interlock, and halt drain.
module mips_exec_pipe import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter bit FWD_EN = 1'b1,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic                     clk1,
  input  logic                     reset,
  mips_exec_pipe_if.slave          bus,
  output logic signed [DATA_W-1:0] alu_result,
  output logic signed [DATA_W-1:0] debug_operand1,
  output logic signed [DATA_W-1:0] debug_operand2,
  output logic                     halted_out,
  output logic                     illegal_op,
  input  logic [REG_AW-1:0]        dbg_raddr,
  output logic signed [DATA_W-1:0] dbg_rdata
);

  logic signed [DATA_W-1:0] rf [NREG];

  logic                     vld_p0;
  logic [31:0]              instr_p0;
  logic                     vld_p1, we_p1;
  logic [5:0]               op_p1;
  logic [REG_AW-1:0]        dest_p1;
  logic signed [DATA_W-1:0] a_p1, b_p1;

  logic                     halt_seen, stall, accept, commit;
  logic [5:0]               op_p0;
  logic [REG_AW-1:0]        rs_p0, rt_p0, rd_p0, dest_p0;
  op_class_e                cls_p0;
  logic                     we_p0, hit_a, hit_b;
  logic signed [DATA_W-1:0] imm_ext_p0, a_p0, b_p0;

  assign op_p0      = instr_p0[OP_LSB +: 6];
  assign rs_p0      = instr_p0[RS_LSB +: REG_AW];
  assign rt_p0      = instr_p0[RT_LSB +: REG_AW];
  assign rd_p0      = instr_p0[RD_LSB +: REG_AW];
  assign imm_ext_p0 = DATA_W'(sext(instr_p0[IMM_LSB +: 16]));
  assign cls_p0     = classify(op_p0);

  // Decode: destination, hazard match against execute, operand selection
  always_comb begin
    dest_p0 = (cls_p0 == RR_ALU) ? rd_p0 : rt_p0;
    we_p0   = ((cls_p0 == RR_ALU) || (cls_p0 == RM_ALU)) && (dest_p0 != '0);
    // we_p1 already excludes R0, so R0 can never match a bypass
    hit_a   = vld_p0 && vld_p1 && we_p1 && (dest_p1 == rs_p0) &&
              ((cls_p0 == RR_ALU) || (cls_p0 == RM_ALU));
    hit_b   = vld_p0 && vld_p1 && we_p1 && (dest_p1 == rt_p0) && (cls_p0 == RR_ALU);
    stall   = !FWD_EN && (hit_a || hit_b);
    a_p0    = (FWD_EN && hit_a) ? alu_result : rf[rs_p0];
    if (cls_p0 == RM_ALU)
      b_p0 = imm_ext_p0;
    else
      b_p0 = (FWD_EN && hit_b) ? alu_result : rf[rt_p0];
  end

  assign bus.instr_ready = !halt_seen && !stall;
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign commit          = vld_p1 && we_p1;

  // Decode register: holds during a stall, rejected cycles load a bubble
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
    end else if (!stall) begin
      vld_p0   <= accept;
      instr_p0 <= accept ? bus.instr : 32'h0;
    end
  end

  // Sticky status: halt accepted, undefined opcode accepted, halt retired
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      halt_seen  <= 1'b0;
      illegal_op <= 1'b0;
      halted_out <= 1'b0;
    end else begin
      if (accept && classify(bus.instr[OP_LSB +: 6]) == HALT)    halt_seen  <= 1'b1;
      if (accept && classify(bus.instr[OP_LSB +: 6]) == ILLEGAL) illegal_op <= 1'b1;
      if (vld_p1 && op_p1 == OP_HLT)                              halted_out <= 1'b1;
    end
  end

  // ---- decode / execute boundary ----
  // Execute register: a stall inserts a bubble behind the held decode entry
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      op_p1   <= '0;
      dest_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else begin
      vld_p1  <= vld_p0 && !stall;
      we_p1   <= we_p0;
      op_p1   <= op_p0;
      dest_p1 <= dest_p0;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
    end
  end

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_p1),
    .a      (a_p1),
    .b      (b_p1),
    .result (alu_result)
  );

  assign debug_operand1 = a_p1;
  assign debug_operand2 = b_p1;

  // ---- execute / writeback boundary ----
  // Register file write and registered writeback report
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
    end else begin
      bus.wb_valid <= commit;
      if (commit) begin
        rf[dest_p1]  <= alu_result;
        bus.wb_addr  <= dest_p1;
        bus.wb_data  <= alu_result;
      end
    end
  end

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];

endmodule

// File: tb/tb_mips_exec_pipe.sv
// Directed bench: one core with bypass, one with interlock, shared clock.
module tb_mips_exec_pipe;

  typedef struct {
    logic [31:0] word;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic        clk;
  logic        rst [2];
  logic        iv  [2];
  logic [31:0] iw  [2];
  logic [4:0]  dra [2];
  logic        rdy [2];
  logic        wbv [2];
  logic [4:0]  wba [2];
  logic [31:0] wbd [2];
  logic [31:0] alu [2];
  logic [31:0] op1 [2];
  logic [31:0] op2 [2];
  logic        halt[2];
  logic        ill [2];
  logic [31:0] drd [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [32];
  int          prog_n;
  logic [4:0]  com_a [$];
  logic [31:0] com_d [$];
  int          com_c [$];
  int          nacc, ready_low, halt_acc, halt_rise;
  vec_t        tbl [13];

  mips_exec_pipe_if #(.DATA_W(32), .REG_AW(5)) bus0 ();
  mips_exec_pipe_if #(.DATA_W(32), .REG_AW(5)) bus1 ();

  assign bus0.instr_valid = iv[0];
  assign bus0.instr       = iw[0];
  assign rdy[0]           = bus0.instr_ready;
  assign wbv[0]           = bus0.wb_valid;
  assign wba[0]           = bus0.wb_addr;
  assign wbd[0]           = bus0.wb_data;
  assign bus1.instr_valid = iv[1];
  assign bus1.instr       = iw[1];
  assign rdy[1]           = bus1.instr_ready;
  assign wbv[1]           = bus1.wb_valid;
  assign wba[1]           = bus1.wb_addr;
  assign wbd[1]           = bus1.wb_data;

  mips_exec_pipe #(.DATA_W(32), .NREG(32), .FWD_EN(1'b1)) u_fwd (
    .clk1(clk), .reset(rst[0]), .bus(bus0),
    .alu_result(alu[0]), .debug_operand1(op1[0]), .debug_operand2(op2[0]),
    .halted_out(halt[0]), .illegal_op(ill[0]),
    .dbg_raddr(dra[0]), .dbg_rdata(drd[0])
  );

  mips_exec_pipe #(.DATA_W(32), .NREG(32), .FWD_EN(1'b0)) u_stl (
    .clk1(clk), .reset(rst[1]), .bus(bus1),
    .alu_result(alu[1]), .debug_operand1(op1[1]), .debug_operand2(op2[1]),
    .halted_out(halt[1]), .illegal_op(ill[1]),
    .dbg_raddr(dra[1]), .dbg_rdata(drd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input int d, input logic [4:0] a, output logic [31:0] v);
    dra[d] = a;
    #1;
    v = drd[d];
  endtask

  // Feed prog[0..prog_n-1] to core d for budget cycles; log commits and events.
  task automatic run_prog(input int d, input bit gaps, input int budget);
    int idx;
    bit acc;
    idx = 0; nacc = 0; ready_low = 0; halt_acc = -1; halt_rise = -1;
    com_a.delete(); com_d.delete(); com_c.delete();
    for (int c = 0; c < budget; c++) begin
      if (idx < prog_n && !(gaps && $urandom_range(0, 2) == 0)) begin
        iv[d] = 1'b1; iw[d] = prog[idx];
      end else begin
        iv[d] = 1'b0; iw[d] = 32'h0;
      end
      @(negedge clk);
      acc = iv[d] && rdy[d];
      if (!rdy[d] && halt_acc < 0) ready_low++;
      if (wbv[d]) begin
        com_a.push_back(wba[d]); com_d.push_back(wbd[d]); com_c.push_back(c);
      end
      if (halt[d] && halt_rise < 0) halt_rise = c;
      @(posedge clk); #1;
      if (acc) begin
        if (prog[idx][31:26] == 6'h3F) halt_acc = c + 1;
        idx++; nacc++;
      end
    end
    iv[d] = 1'b0; iw[d] = 32'h0;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1; iv[d] = 1'b0; iw[d] = 32'h0;
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic load_basic();
    prog[0] = 32'h2801000A; prog[1] = 32'h28020014;
    prog[2] = 32'h00221800; prog[3] = 32'hFC000000;
    prog_n = 4;
  endtask

  task automatic chk_basic(input string tag, input int d, input int add_cyc);
    logic [31:0] v;
    chk({tag, "_ncommit"}, com_a.size(), 3);
    chk({tag, "_c0"}, {com_a[0], com_d[0]}, {5'd1, 32'd10});
    chk({tag, "_c1"}, {com_a[1], com_d[1]}, {5'd2, 32'd20});
    chk({tag, "_c2"}, {com_a[2], com_d[2]}, {5'd3, 32'd30});
    chk({tag, "_add_commit_cycle"}, com_c[2], add_cyc);
    rd(d, 5'd3, v);
    chk({tag, "_r3"}, v, 32'd30);
  endtask

  initial begin
    logic [31:0] v;
    int j, nexp;
    tbl[0]  = '{32'h2801000A, 1'b1, 5'd1,  32'd10};
    tbl[1]  = '{32'h2805FFFD, 1'b1, 5'd5,  32'hFFFFFFFD};
    tbl[2]  = '{32'h10A13000, 1'b1, 5'd6,  32'd1};
    tbl[3]  = '{32'h04013800, 1'b1, 5'd7,  32'hFFFFFFF6};
    tbl[4]  = '{32'h14214000, 1'b1, 5'd8,  32'd100};
    tbl[5]  = '{32'h28000005, 1'b0, 5'd0,  32'd0};
    tbl[6]  = '{32'h00002000, 1'b1, 5'd4,  32'd0};
    tbl[7]  = '{32'h30E9FFFB, 1'b1, 5'd9,  32'd1};
    tbl[8]  = '{32'h2D0A0001, 1'b1, 5'd10, 32'd99};
    tbl[9]  = '{32'h0CE15800, 1'b1, 5'd11, 32'hFFFFFFFE};
    tbl[10] = '{32'h096A6000, 1'b1, 5'd12, 32'd98};
    tbl[11] = '{32'h10256800, 1'b1, 5'd13, 32'd0};
    tbl[12] = '{32'hFC000000, 1'b0, 5'd0,  32'd0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; iw[d] = 32'h0; dra[d] = 5'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", rdy[d], 1'b1);
      chk("reset_wb", {wbv[d], wba[d], wbd[d]}, '0);
      chk("reset_flags", {halt[d], ill[d]}, 2'b00);
    end

    // Back-to-back dependent program with bypass
    load_basic();
    run_prog(0, 1'b0, 12);
    chk_basic("fwd", 0, 5);
    chk("fwd_ready_low", ready_low, 0);
    chk("fwd_halt_acc", halt_acc, 4);
    chk("fwd_halt_rise", halt_rise, 6);

    // Same program with interlock: one stall cycle, everything one later
    run_prog(1, 1'b0, 12);
    chk_basic("stl", 1, 6);
    chk("stl_ready_low", ready_low, 1);
    chk("stl_halt_rise", halt_rise, 7);

    // Table-driven ALU, sign, wrap and R0 vectors on both cores
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int i = 0; i < 13; i++) prog[i] = tbl[i].word;
      prog_n = 13;
      run_prog(d, 1'b0, 25);
      nexp = 0;
      for (int i = 0; i < 13; i++) if (tbl[i].wr) nexp++;
      chk("tbl_ncommit", com_a.size(), nexp);
      j = 0;
      for (int i = 0; i < 13; i++) begin
        if (tbl[i].wr) begin
          chk($sformatf("tbl%0d_d%0d_commit", i, d), {com_a[j], com_d[j]}, {tbl[i].addr, tbl[i].data});
          rd(d, tbl[i].addr, v);
          chk($sformatf("tbl%0d_d%0d_reg", i, d), v, tbl[i].data);
          j++;
        end
      end
      rd(d, 5'd0, v);
      chk("tbl_r0", v, 32'd0);
      chk("tbl_halted", halt[d], 1'b1);
      chk("tbl_no_illegal", ill[d], 1'b0);
    end

    // Gapped stream with illegal opcode and words offered after HLT
    do_reset(0);
    prog[0] = 32'h28010007; prog[1] = 32'h28020003; prog[2] = 32'h80211000;
    prog[3] = 32'h00221800; prog[4] = 32'hFC000000; prog[5] = 32'h28040001;
    prog[6] = 32'h28050001;
    prog_n = 7;
    run_prog(0, 1'b1, 40);
    chk("gap_ncommit", com_a.size(), 3);
    chk("gap_c0", {com_a[0], com_d[0]}, {5'd1, 32'd7});
    chk("gap_c1", {com_a[1], com_d[1]}, {5'd2, 32'd3});
    chk("gap_c2", {com_a[2], com_d[2]}, {5'd3, 32'd10});
    chk("gap_naccept", nacc, 5);
    chk("gap_flags", {halt[0], ill[0]}, 2'b11);
    rd(0, 5'd2, v); chk("gap_r2", v, 32'd3);
    rd(0, 5'd4, v); chk("gap_r4", v, 32'd0);
    rd(0, 5'd5, v); chk("gap_r5", v, 32'd0);

    // Reset while instructions are in flight on the interlocked core
    do_reset(1);
    iv[1] = 1'b1; iw[1] = 32'h80211000;
    @(posedge clk); #1;
    chk("mid_illegal_set", ill[1], 1'b1);
    iw[1] = 32'h2801000A;
    @(posedge clk); #1;
    iw[1] = 32'h28020014;
    @(posedge clk); #1;
    iv[1] = 1'b0; iw[1] = 32'h0;
    @(posedge clk); #1;
    chk("mid_wb_before", {wbv[1], wba[1], wbd[1]}, {1'b1, 5'd1, 32'd10});
    rst[1] = 1'b1;
    #1;
    chk("mid_wb_cleared", {wbv[1], wba[1], wbd[1]}, '0);
    chk("mid_flags_cleared", {halt[1], ill[1]}, 2'b00);
    chk("mid_alu_cleared", alu[1], 32'd0);
    rd(1, 5'd1, v); chk("mid_r1_cleared", v, 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("mid_ready_after", rdy[1], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_no_late_commit", wbv[1], 1'b0);
    rd(1, 5'd2, v); chk("mid_r2_lost", v, 32'd0);
    load_basic();
    run_prog(1, 1'b0, 12);
    chk_basic("mid_fresh", 1, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_pipe.md
Name: mips_exec_pipe

Overview:
Parametrised three-stage (decode, execute, writeback) integer execution core for the pipe_MIPS20 family. It accepts instructions over a valid/ready stream and holds an internal register file. A bypass path removes the software NOP padding that the current core needs between dependent instructions. An interlock mode (FWD_EN=0) stalls instead of forwarding, and a HLT instruction drains the pipeline and then freezes it.

Parameters:
DATA_W, 32, datapath and register width; legal range 16..64.
NREG, 32, number of architectural registers; power of 2, 2..32; REG_AW = clog2(NREG).
FWD_EN, 1, 1 = execute-to-decode bypass; 0 = hazard interlock (one-cycle stall).

Ports:
clk1  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
instr_valid  in  1  instr holds a valid instruction.
instr  in  32  instruction word; fields op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
instr_ready  out  1  core accepts instr on this edge.
wb_valid  out  1  registered; one writeback committed on the previous edge.
wb_addr  out  REG_AW  destination of the committed writeback.
wb_data  out  DATA_W  value of the committed writeback.
alu_result  out  DATA_W  combinational ALU output of the execute stage.
debug_operand1  out  DATA_W  execute-stage operand A.
debug_operand2  out  DATA_W  execute-stage operand B (register value or sign-extended imm).
halted_out  out  1  sticky; HLT has retired.
illegal_op  out  1  sticky; an undefined opcode was accepted.
dbg_raddr  in  REG_AW  asynchronous register-file read address.
dbg_rdata  out  DATA_W  Reg[dbg_raddr]; reads 0 for address 0.

Behaviour:
- Reset (async): all pipeline valids = 0; registers 0..NREG-1 = 0; wb_valid = 0, wb_addr = 0, wb_data = 0; halted_out = 0; illegal_op = 0. After release, instr_ready = 1 in the first cycle.
- Opcodes, R-type (A = Reg[rs], B = Reg[rt], dest = rd): ADD 0x00, SUB 0x01, AND 0x02, OR 0x03, SLT 0x04, MUL 0x05.
- Opcodes, I-type (A = Reg[rs], B = sext(imm), dest = rt): ADDI 0x0A, SUBI 0x0B, SLTI 0x0C.
- HLT = 0x3F. Any other opcode is executed as a NOP and sets illegal_op.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^DATA_W; MUL keeps the low DATA_W bits.
  - SLT and SLTI are signed and produce 1 or 0.
  - Register and immediate fields wider than REG_AW are truncated to REG_AW bits.
- Handshake: an instruction is accepted when instr_valid && instr_ready. No accept means a bubble enters decode. instr_ready = !halt_seen && !stall.
- Pipeline: accept at edge k (decode register). Operands resolve and the execute register loads at k+1. The register file writes at k+2, and wb_valid/wb_addr/wb_data are visible from k+2 until k+3. Accept-to-commit latency is 2 cycles; throughput is 1 per cycle.
- R0: writes are discarded, wb_valid stays 0 for dest 0, and R0 never matches a bypass. The all-zero word (ADD R0,R0,R0) is therefore a true NOP.
- Hazards:
  - The only in-flight producer is the execute stage; anything older is already in the register file.
  - FWD_EN=1: if E is valid and writes a non-zero dest equal to rs or rt in decode, take alu_result for that operand. No stall ever occurs.
  - FWD_EN=0: the same match forces stall = 1 for exactly one cycle. Decode holds, a bubble enters execute, and instr_ready = 0.
- HLT:
  - On accept, halt_seen = 1 and instr_ready drops to 0 permanently.
  - HLT travels down the pipe as a non-writing op; older instructions complete normally.
  - halted_out = 1 on the edge at which HLT would commit (k+2) and holds until reset.
- Simultaneous events: a register-file write and a decode read of the same register in the same cycle are already covered by the bypass (FWD_EN=1) or the stall (FWD_EN=0), so no write-through is required.
- Reset mid-operation flushes in-flight instructions with no commit; partial results are lost.

Decomposition:
- Package mips_pkg: opcode localparams, instruction field bit positions, an op-class enum (RR_ALU, RM_ALU, HALT, ILLEGAL) and the sext helper function.
- Sub-module mips_alu: combinational; inputs op, A and B, parametrised by DATA_W; output is the result.
- Register file, pipeline registers and hazard logic stay in mips_exec_pipe.

Test Plan:
1. FWD_EN=1, back-to-back ADDI R1,R0,10 (2801000A); ADDI R2,R0,20 (28020014); ADD R3,R1,R2 (00221800); HLT (FC000000) with no NOPs.
   -> wb sequence (1,10), (2,20), (3,30); instr_ready never drops before HLT; halted_out 2 cycles after HLT accept; dbg_rdata[3] = 30.
2. FWD_EN=0, same program.
   -> instr_ready = 0 for exactly one cycle while ADD sits in decode; Reg[3] = 30; halted_out one cycle later than in scenario 1.
3. Signed and wrap checks: ADDI R5,R0,0xFFFD; SLT R6,R5,R1 (R1=10); SUB R7,R0,R1.
   -> R5 = 0xFFFFFFFD, R6 = 1, R7 = 0xFFFFFFF6; MUL of R1 by R1 gives 100.
4. R0 protection: ADDI R0,R0,5 then ADD R4,R0,R0.
   -> no wb_valid for the first instruction; R4 = 0.
5. Handshake and illegal opcode: random instr_valid gaps, opcode 0x20 injected, HLT followed by further valid words.
   -> each word commits exactly once and in order; illegal_op = 1; no register change from the illegal word; post-HLT words are never accepted.
6. Reset asserted while three instructions are in flight.
   -> all outputs and registers read 0 immediately; instr_ready = 1 after release; a fresh program executes correctly.
